// File: rtl/cdc_src_packer_if.sv
// Handshake bundle for cdc_src_packer: narrow input beat stream in, packed word out.
// master = upstream/downstream environment view, slave = packer view.
interface cdc_src_packer_if #(
  parameter int IW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO) + 1
);
  logic [IW-1:0]       in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [IW*RATIO-1:0] out_data;
  logic [CW-1:0]       out_cnt;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_cnt, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_cnt, out_last, out_valid
  );
endinterface

// File: rtl/cdc_src_packer.sv
// Packs up to RATIO narrow beats into one wide word ahead of the 4-phase CDC.
// Optional idle flush of partial words: define CDC_PACK_TIMEOUT_EN.
module cdc_src_packer #(
  parameter int IW      = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(RATIO) + 1,
  localparam int LW     = $clog2(RATIO)
) (
  input  logic               src_clk_i,
  input  logic               src_rst_ni,
  cdc_src_packer_if.slave    pk
);
  typedef logic [RATIO-1:0][IW-1:0] lanes_t;

  lanes_t              lanes_q, lanes_d, merged;
  logic [LW-1:0]       lane_q, lane_d;
  logic                full_q, full_d;
  logic [CW-1:0]       pcnt_q, pcnt_d;
  logic                plast_q, plast_d;
  logic [IW*RATIO-1:0] odata_q, odata_d;
  logic [CW-1:0]       ocnt_q, ocnt_d;
  logic                olast_q, olast_d;
  logic                ovalid_q, ovalid_d;

  logic acc, out_free, complete;

  assign acc      = pk.in_valid & ~full_q;
  assign out_free = ~ovalid_q | pk.out_ready;
  assign complete = (lane_q == LW'(RATIO-1)) | pk.in_last;

  // Pack lanes with the incoming beat dropped into the current lane.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign merged[i] = (lane_q == LW'(i)) ? pk.in_data : lanes_q[i];
  end

`ifdef CDC_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          flush;

  // idle_q saturates at TIMEOUT-1 so a blocked flush fires once the output frees.
  assign flush = (lane_q != '0) & ~full_q & ~acc & (idle_q == TW'(TIMEOUT-1)) & out_free;

  always_comb begin
    idle_d = idle_q;
    if (acc || lane_q == '0 || full_q) idle_d = '0;
    else if (idle_q != TW'(TIMEOUT-1)) idle_d = idle_q + 1'b1;
    if (flush) idle_d = '0;
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) idle_q <= '0;
    else             idle_q <= idle_d;
  end
`endif

  always_comb begin
    lanes_d  = lanes_q;
    lane_d   = lane_q;
    full_d   = full_q;
    pcnt_d   = pcnt_q;
    plast_d  = plast_q;
    odata_d  = odata_q;
    ocnt_d   = ocnt_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q & ~pk.out_ready;
    if (full_q) begin
      if (out_free) begin
        odata_d  = lanes_q;
        ocnt_d   = pcnt_q;
        olast_d  = plast_q;
        ovalid_d = 1'b1;
        lanes_d  = '0;
        lane_d   = '0;
        full_d   = 1'b0;
      end
    end else if (acc) begin
      if (complete) begin
        if (out_free) begin
          odata_d  = merged;
          ocnt_d   = CW'(lane_q) + 1'b1;
          olast_d  = pk.in_last;
          ovalid_d = 1'b1;
          lanes_d  = '0;
          lane_d   = '0;
        end else begin
          lanes_d = merged;
          pcnt_d  = CW'(lane_q) + 1'b1;
          plast_d = pk.in_last;
          full_d  = 1'b1;
        end
      end else begin
        lanes_d = merged;
        lane_d  = lane_q + 1'b1;
      end
    end
`ifdef CDC_PACK_TIMEOUT_EN
    else if (flush) begin
      odata_d  = lanes_q;
      ocnt_d   = CW'(lane_q);
      olast_d  = 1'b0;
      ovalid_d = 1'b1;
      lanes_d  = '0;
      lane_d   = '0;
    end
`endif
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      lanes_q  <= '0;
      lane_q   <= '0;
      full_q   <= 1'b0;
      pcnt_q   <= '0;
      plast_q  <= 1'b0;
      odata_q  <= '0;
      ocnt_q   <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      lanes_q  <= lanes_d;
      lane_q   <= lane_d;
      full_q   <= full_d;
      pcnt_q   <= pcnt_d;
      plast_q  <= plast_d;
      odata_q  <= odata_d;
      ocnt_q   <= ocnt_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign pk.in_ready  = ~full_q;
  assign pk.out_data  = odata_q;
  assign pk.out_cnt   = ocnt_q;
  assign pk.out_last  = olast_q;
  assign pk.out_valid = ovalid_q;
endmodule

// File: tb/tb_cdc_src_packer.sv
// Directed bench for cdc_src_packer (IW=8, RATIO=4); timeout steps run only when
// CDC_PACK_TIMEOUT_EN is defined.
module tb_cdc_src_packer;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  cdc_src_packer_if #(.IW(8), .RATIO(4)) bif ();

  cdc_src_packer #(.IW(8), .RATIO(4), .TIMEOUT(16)) dut (
    .src_clk_i  (clk),
    .src_rst_ni (rst_n),
    .pk         (bif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    bif.in_data  = d;
    bif.in_valid = 1'b1;
    bif.in_last  = last;
    tick();
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
    chk({tag, ".valid"}, 64'(bif.out_valid), 64'd1);
    chk({tag, ".data"},  64'(bif.out_data),  64'(d));
    chk({tag, ".cnt"},   64'(bif.out_cnt),   64'(c));
    chk({tag, ".last"},  64'(bif.out_last),  64'(l));
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.in_data   = '0;
    bif.in_valid  = 1'b0;
    bif.in_last   = 1'b0;
    bif.out_ready = 1'b1;
    tick(); tick();
    chk("rst.valid", 64'(bif.out_valid), 64'd0);
    chk("rst.data",  64'(bif.out_data),  64'd0);
    chk("rst.cnt",   64'(bif.out_cnt),   64'd0);
    chk("rst.last",  64'(bif.out_last),  64'd0);
    chk("rst.ready", 64'(bif.in_ready),  64'd1);
    rst_n = 1'b1;
    tick();

    // Full word
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0);
    chk("full.pre", 64'(bif.out_valid), 64'd0);
    beat(8'h44, 0);
    chk_word("full", 32'h44332211, 3'd4, 1'b0);
    tick();
    chk("full.drain", 64'(bif.out_valid), 64'd0);

    // Last closes early, single-beat last, last on final lane
    beat(8'hAA, 0); beat(8'hBB, 1);
    chk_word("last2", 32'h0000BBAA, 3'd2, 1'b1);
    beat(8'h77, 1);
    chk_word("last1", 32'h00000077, 3'd1, 1'b1);
    beat(8'hE0, 0); beat(8'hE1, 0); beat(8'hE2, 0); beat(8'hE3, 1);
    chk_word("last4", 32'hE3E2E1E0, 3'd4, 1'b1);
    tick();

    // Backpressure: second word parks in the pack register
    bif.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i), 0);
      if (i < 8) chk("bp.ready", 64'(bif.in_ready), 64'd1);
    end
    chk("bp.full", 64'(bif.in_ready), 64'd0);
    chk_word("bp.w0", 32'h04030201, 3'd4, 1'b0);
    tick(); tick();
    chk_word("bp.hold", 32'h04030201, 3'd4, 1'b0);
    chk("bp.full2", 64'(bif.in_ready), 64'd0);
    bif.out_ready = 1'b1;
    tick();
    chk_word("bp.w1", 32'h08070605, 3'd4, 1'b0);
    chk("bp.rel", 64'(bif.in_ready), 64'd1);
    tick();
    chk("bp.drain", 64'(bif.out_valid), 64'd0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      chk("st.ready", 64'(bif.in_ready), 64'd1);
      beat(8'h10 + 8'(i), 0);
      if (i == 3) chk_word("st.w0", 32'h13121110, 3'd4, 1'b0);
      if (i == 4) chk("st.gap", 64'(bif.out_valid), 64'd0);
      if (i == 7) chk_word("st.w1", 32'h17161514, 3'd4, 1'b0);
    end
    tick();

`ifdef CDC_PACK_TIMEOUT_EN
    beat(8'h5A, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("to.early", 64'(bif.out_valid), 64'd0);
    tick();
    chk_word("to.flush", 32'h0000005A, 3'd1, 1'b0);
    tick();
    beat(8'h5B, 0);
    for (int i = 0; i < 15; i++) tick();
    beat(8'h6C, 0);
    chk("to.supp", 64'(bif.out_valid), 64'd0);
    beat(8'h7D, 1);
    chk_word("to.after", 32'h007D6C5B, 3'd3, 1'b1);
    tick();
`endif

    // Reset mid-operation with an output word held and a partial word pending
    bif.out_ready = 1'b0;
    beat(8'hA0, 0); beat(8'hA1, 0); beat(8'hA2, 0); beat(8'hA3, 0);
    beat(8'hC1, 0); beat(8'hC2, 0);
    chk("mid.busy", 64'(bif.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 64'(bif.out_valid), 64'd0);
    chk("mid.data",  64'(bif.out_data),  64'd0);
    chk("mid.cnt",   64'(bif.out_cnt),   64'd0);
    chk("mid.ready", 64'(bif.in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    beat(8'hD1, 0); beat(8'hD2, 0); beat(8'hD3, 0); beat(8'hD4, 0);
    chk_word("mid.next", 32'hD4D3D2D1, 3'd4, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
